// File: rtl/lfsr_bank.sv
// Bank of independent Fibonacci LFSRs, one per comparator channel, with runtime reseeding
// over a valid/ready handshake and a warm-up qualifier on the output words.
module lfsr_bank #(
    parameter int unsigned     LFSR               = 12,
    parameter int unsigned     LFSR_TO_COMPARATOR = 8,
    parameter int unsigned     CHANNELS           = 4,
    parameter logic [LFSR-1:0] TAPS               = 12'h829,
    parameter logic [LFSR-1:0] SEED_BASE          = 12'h815,
    parameter logic [LFSR-1:0] SEED_STRIDE        = 12'h2C7,
    parameter int unsigned     WARMUP             = 16
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_en,
    input  logic                                         i_seed_valid,
    output logic                                         o_seed_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] i_seed_ch,
    input  logic [LFSR-1:0]                              i_seed_data,
    output logic [CHANNELS*LFSR_TO_COMPARATOR-1:0]       o_out,
    output logic                                         o_out_valid,
    output logic                                         o_zero_seed_err
);

    localparam int unsigned OW    = LFSR_TO_COMPARATOR;
    localparam int unsigned CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    logic [LFSR-1:0]        r_state [CHANNELS];
    logic [CHANNELS*OW-1:0] r_out;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_out_valid;
    logic                   r_seed_ready;
    logic                   r_zero_seed_err;

    logic                   w_accept;
    logic                   w_load_hit;
    logic                   w_seed_zero;
    logic [LFSR-1:0]        w_seed_val;
    logic [CHANNELS-1:0]    w_load_ch;
    logic                   w_cnt_full;

    // Channel c resets to SEED_BASE ^ (c * SEED_STRIDE), never to the all-zero lock-up state.
    function automatic logic [LFSR-1:0] reset_seed(input int unsigned ch);
        logic [LFSR-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < ch; i++) begin
            acc = acc + SEED_STRIDE;
        end
        acc = acc ^ SEED_BASE;
        if (acc == '0) begin
            acc = LFSR'(1);
        end
        return acc;
    endfunction

    function automatic logic [LFSR-1:0] lfsr_step(input logic [LFSR-1:0] s);
        return {s[LFSR-2:0], ^(s & TAPS)};
    endfunction

    assign w_accept    = i_seed_valid && r_seed_ready && !i_rst;
    assign w_load_hit  = w_accept && (32'(i_seed_ch) < CHANNELS);
    assign w_seed_zero = (i_seed_data == '0);
    assign w_seed_val  = w_seed_zero ? LFSR'(1) : i_seed_data;
    assign w_cnt_full  = (r_cnt == CNT_W'(WARMUP));

    always_comb begin
        w_load_ch = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            w_load_ch[c] = w_load_hit && (32'(i_seed_ch) == c);
        end
    end

    // Output words sample the pre-edge state, so a load shows up one edge later.
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (i_rst) begin
                r_state[c]       <= reset_seed(c);
                r_out[c*OW +: OW] <= '0;
            end else begin
                if (w_load_ch[c]) begin
                    r_state[c] <= w_seed_val;
                end else if (i_en) begin
                    r_state[c] <= lfsr_step(r_state[c]);
                end
                if (i_en) begin
                    r_out[c*OW +: OW] <= r_state[c][LFSR-1 -: OW];
                end
            end
        end
    end

    // A load disqualifies the whole bank; an out-of-range channel only completes the handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt           <= '0;
            r_out_valid     <= 1'b0;
            r_seed_ready    <= 1'b0;
            r_zero_seed_err <= 1'b0;
        end else begin
            r_seed_ready <= !w_accept;
            if (w_load_hit) begin
                r_cnt       <= '0;
                r_out_valid <= 1'b0;
                if (w_seed_zero) begin
                    r_zero_seed_err <= 1'b1;
                end
            end else if (i_en) begin
                r_out_valid <= w_cnt_full;
                if (!w_cnt_full) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_out           = r_out;
    assign o_out_valid     = r_out_valid;
    assign o_seed_ready    = r_seed_ready;
    assign o_zero_seed_err = r_zero_seed_err;

endmodule
